hub75_framebuffer: RTL

Dual-bank, double-buffered RGB565 pixel store sitting directly upstream of the HUB75 LED scan engine. It accepts pixel writes by (x, y) coordinate from a loader, and returns the interleaved pixel pair (row r, row r + H/2) for each scan read address. Frame swaps are deferred to the scan engine's address wrap so that a frame is never displayed half-updated.

---
 rtl/hub75_framebuffer_if.sv | 32 +++
 rtl/hub75_framebuffer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/hub75_framebuffer_if.sv
// Loader write port and scan read port of the HUB75 framebuffer.
// master = loader/scan side, slave = framebuffer.
interface hub75_framebuffer_if #(
  parameter int unsigned MATRIX_HEIGHT = 64,
  parameter int unsigned MATRIX_WIDTH  = 64
);
  localparam int unsigned AW = $clog2(MATRIX_HEIGHT * MATRIX_WIDTH / 2);
  localparam int unsigned XW = $clog2(MATRIX_WIDTH);
  localparam int unsigned YW = $clog2(MATRIX_HEIGHT);

  logic          wr_valid;
  logic          wr_ready;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic [15:0]   wr_data;
  logic          wr_last;
  logic [AW-1:0] r_addr;
  logic [15:0]   rgb_0;
  logic [15:0]   rgb_1;
  logic          swap_pending;
  logic          frame_swapped;

  modport master (
    output wr_valid, wr_x, wr_y, wr_data, wr_last, r_addr,
    input  wr_ready, rgb_0, rgb_1, swap_pending, frame_swapped
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_data, wr_last, r_addr,
    output wr_ready, rgb_0, rgb_1, swap_pending, frame_swapped
  );
endinterface

// File: rtl/hub75_framebuffer.sv
// RGB565 pixel store for a HUB75 scan engine, returning top/bottom pixel pairs.
// FRAMEBUF_DOUBLE_BUFFER_EN enables front/back buffers with swaps deferred to the scan wrap.
module hub75_framebuffer #(
  parameter int unsigned MATRIX_HEIGHT = 64,
  parameter int unsigned MATRIX_WIDTH  = 64
) (
  input logic                clk,
  input logic                rst,
  hub75_framebuffer_if.slave bus
);
  localparam int unsigned Depth = MATRIX_HEIGHT * MATRIX_WIDTH / 2;
  localparam int unsigned AW    = $clog2(Depth);
  localparam int unsigned YW    = $clog2(MATRIX_HEIGHT);
  localparam logic [AW-1:0] LAST = AW'(Depth - 1);
`ifdef FRAMEBUF_DOUBLE_BUFFER_EN
  localparam int unsigned NumBuf = 2;
`else
  localparam int unsigned NumBuf = 1;
`endif

  typedef enum logic [1:0] {StClear, StWrite, StWaitSwap} state_e;

  state_e        state_q;
  logic [AW-1:0] clr_cnt_q;
  logic [AW-1:0] prev_addr_q;
  logic          wr_buf;
  logic          rd_buf;
  logic          wr_fire;
  logic          wr_half;
  logic [AW-1:0] wr_addr;
  logic          wrap;

  logic [15:0] mem_top [NumBuf][Depth];
  logic [15:0] mem_bot [NumBuf][Depth];

`ifdef FRAMEBUF_DOUBLE_BUFFER_EN
  logic front_sel_q;
  assign rd_buf = front_sel_q;
  assign wr_buf = ~front_sel_q;
`else
  logic unused_wr_last;
  assign unused_wr_last = bus.wr_last;
  assign rd_buf = 1'b0;
  assign wr_buf = 1'b0;
`endif

  assign wr_fire = bus.wr_valid && bus.wr_ready;
  // Bottom-half rows fold onto the same addresses as the top half.
  assign wr_half = bus.wr_y[YW-1];
  assign wr_addr = {bus.wr_y[YW-2:0], bus.wr_x};
  assign wrap    = (prev_addr_q == LAST) && (bus.r_addr == '0);

  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem_top[1'b0][clr_cnt_q] <= 16'h0000;
      mem_bot[1'b0][clr_cnt_q] <= 16'h0000;
`ifdef FRAMEBUF_DOUBLE_BUFFER_EN
      mem_top[1'b1][clr_cnt_q] <= 16'h0000;
      mem_bot[1'b1][clr_cnt_q] <= 16'h0000;
`endif
    end else if (wr_fire) begin
      if (wr_half) begin
        mem_bot[wr_buf][wr_addr] <= bus.wr_data;
      end else begin
        mem_top[wr_buf][wr_addr] <= bus.wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rgb_0 <= 16'h0000;
      bus.rgb_1 <= 16'h0000;
    end else begin
      bus.rgb_0 <= mem_top[rd_buf][bus.r_addr];
      bus.rgb_1 <= mem_bot[rd_buf][bus.r_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= StClear;
      clr_cnt_q         <= '0;
      prev_addr_q       <= '0;
      bus.wr_ready      <= 1'b0;
      bus.swap_pending  <= 1'b0;
      bus.frame_swapped <= 1'b0;
`ifdef FRAMEBUF_DOUBLE_BUFFER_EN
      front_sel_q       <= 1'b0;
`endif
    end else begin
      prev_addr_q <= bus.r_addr;
`ifdef FRAMEBUF_DOUBLE_BUFFER_EN
      bus.frame_swapped <= 1'b0;
`else
      bus.frame_swapped <= wrap;
`endif
      case (state_q)
        StClear: begin
          if (clr_cnt_q == LAST) begin
            state_q      <= StWrite;
            bus.wr_ready <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        StWrite: begin
`ifdef FRAMEBUF_DOUBLE_BUFFER_EN
          // A wrap seen in this state is ignored, so a frame closed on a wrap waits a full scan.
          if (wr_fire && bus.wr_last) begin
            state_q          <= StWaitSwap;
            bus.wr_ready     <= 1'b0;
            bus.swap_pending <= 1'b1;
          end
`endif
        end
`ifdef FRAMEBUF_DOUBLE_BUFFER_EN
        StWaitSwap: begin
          if (wrap) begin
            state_q           <= StWrite;
            front_sel_q       <= ~front_sel_q;
            bus.frame_swapped <= 1'b1;
            bus.swap_pending  <= 1'b0;
            bus.wr_ready      <= 1'b1;
          end
        end
`endif
        default: state_q <= StClear;
      endcase
    end
  end
endmodule
